// File: rtl/rob_commit_pkg.sv
// rob_commit_pkg: shared types and constants for the reorder buffer.
//   ROB_DEPTH   number of ROB entries (power of two)
//   ROB_IDX_W   width of a ROB index / head / tail pointer
//   PREG_W      physical register tag width
//   ROB_N_CMP   number of functional-unit completion ports
//   ARCH_W      architectural register index width
//   rob_row_t   one ROB entry: valid, done, destination info and PC
package rob_commit_pkg;

  localparam int ROB_DEPTH = 16;
  localparam int ROB_IDX_W = 4;
  localparam int PREG_W    = 6;
  localparam int ROB_N_CMP = 3;
  localparam int ARCH_W    = 5;

  typedef struct packed {
    logic              v;
    logic              done;
    logic [ARCH_W-1:0] rd;
    logic [PREG_W-1:0] pd;
    logic [PREG_W-1:0] old_pd;
    logic              has_dest;
    logic [31:0]       pc;
  } rob_row_t;

  // Number of dispatch slots accepted this cycle. Slot 2 only counts when
  // slot 1 is also valid, so a lone slot-2 request is ignored.
  function automatic logic [1:0] accepted_slots(input logic ready,
                                                input logic v1,
                                                input logic v2);
    logic [1:0] n;
    n = 2'd0;
    if (ready && v1) begin
      n = v2 ? 2'd2 : 2'd1;
    end
    return n;
  endfunction

endpackage

// File: rtl/rob_retire_sel.sv
// rob_retire_sel: combinational retire decision for the two oldest entries.
// Ports:
//   head_v, head_done   state of the entry at head
//   next_v, next_done   state of the entry at head+1
//   ret_en_1            head entry retires this cycle
//   ret_en_2            head+1 entry retires this cycle (only with ret_en_1)
//   n_retire            number of entries retiring (0..2)
module rob_retire_sel (
  input  logic       head_v,
  input  logic       head_done,
  input  logic       next_v,
  input  logic       next_done,
  output logic       ret_en_1,
  output logic       ret_en_2,
  output logic [1:0] n_retire
);

  // In-order commit: the younger entry may only follow the older one out.
  assign ret_en_1 = head_v & head_done;
  assign ret_en_2 = ret_en_1 & next_v & next_done;
  assign n_retire = {1'b0, ret_en_1} + {1'b0, ret_en_2};

endmodule

// File: rtl/rob_commit.sv
// rob_commit: 16-entry reorder buffer with a 2-wide in-order commit stage.
// Optional feature macro: ROB_FLUSH_EN adds a 'flush' input that empties
// the ROB at the next posedge (rst has priority).
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   flush                         (ROB_FLUSH_EN only) discard all entries
//   alloc_valid_1/_2              dispatch allocation requests, slot 2 younger
//   alloc_rd/pd/old_pd/has_dest/pc_1/_2   entry payload per slot
//   alloc_ready                   room for two entries (from registered count)
//   alloc_idx_1/_2                ROB index assigned to each slot
//   cmp_valid, cmp_idx            per-FU completion strobes and ROB indices
//   ret_valid_1/_2                one-cycle retire pulses, slot 1 older
//   ret_rd/pd/old_pd/free/pc_1/_2 retired entry info; free = valid & has_dest
//   count                         occupied entries, 0..DEPTH
// Handshake: an allocation is taken on the posedge where alloc_ready and
// alloc_valid_1 are both high (slot 2 additionally needs alloc_valid_2);
// requests made while alloc_ready is low are dropped, not held.
module rob_commit
  import rob_commit_pkg::*;
#(
  parameter int DEPTH = ROB_DEPTH,
  parameter int IDX_W = ROB_IDX_W,
  parameter int N_CMP = ROB_N_CMP
) (
  input  logic                   clk,
  input  logic                   rst,
`ifdef ROB_FLUSH_EN
  input  logic                   flush,
`endif
  input  logic                   alloc_valid_1,
  input  logic                   alloc_valid_2,
  input  logic [ARCH_W-1:0]      alloc_rd_1,
  input  logic [ARCH_W-1:0]      alloc_rd_2,
  input  logic [PREG_W-1:0]      alloc_pd_1,
  input  logic [PREG_W-1:0]      alloc_pd_2,
  input  logic [PREG_W-1:0]      alloc_old_pd_1,
  input  logic [PREG_W-1:0]      alloc_old_pd_2,
  input  logic                   alloc_has_dest_1,
  input  logic                   alloc_has_dest_2,
  input  logic [31:0]            alloc_pc_1,
  input  logic [31:0]            alloc_pc_2,
  output logic                   alloc_ready,
  output logic [IDX_W-1:0]       alloc_idx_1,
  output logic [IDX_W-1:0]       alloc_idx_2,
  input  logic [N_CMP-1:0]       cmp_valid,
  input  logic [N_CMP*IDX_W-1:0] cmp_idx,
  output logic                   ret_valid_1,
  output logic                   ret_valid_2,
  output logic [ARCH_W-1:0]      ret_rd_1,
  output logic [ARCH_W-1:0]      ret_rd_2,
  output logic [PREG_W-1:0]      ret_pd_1,
  output logic [PREG_W-1:0]      ret_pd_2,
  output logic [PREG_W-1:0]      ret_old_pd_1,
  output logic [PREG_W-1:0]      ret_old_pd_2,
  output logic                   ret_free_1,
  output logic                   ret_free_2,
  output logic [31:0]            ret_pc_1,
  output logic [31:0]            ret_pc_2,
  output logic [IDX_W:0]         count
);

  logic [IDX_W-1:0] head_q;
  logic [IDX_W-1:0] tail_q;
  logic [IDX_W:0]   count_q;
  rob_row_t         rob_q [DEPTH];
  rob_row_t         rob_d [DEPTH];

  logic             flush_w;
  logic [IDX_W-1:0] head_p1;
  logic [IDX_W-1:0] tail_p1;
  logic [1:0]       n_alloc;
  logic             accept_1;
  logic             accept_2;
  logic             ret_en_1;
  logic             ret_en_2;
  logic [1:0]       n_retire;

`ifdef ROB_FLUSH_EN
  assign flush_w = flush;
`else
  assign flush_w = 1'b0;
`endif

  // Pointer arithmetic wraps naturally at IDX_W bits (DEPTH is a power of 2).
  assign head_p1 = head_q + IDX_W'(1);
  assign tail_p1 = tail_q + IDX_W'(1);

  // Ready is taken from the pre-edge count, so it stays conservative on
  // cycles where retirement frees entries at the same edge.
  assign alloc_ready = (count_q <= (IDX_W+1)'(DEPTH - 2));
  assign alloc_idx_1 = tail_q;
  assign alloc_idx_2 = tail_p1;
  assign count       = count_q;

  assign n_alloc  = accepted_slots(alloc_ready, alloc_valid_1, alloc_valid_2);
  assign accept_1 = n_alloc != 2'd0;
  assign accept_2 = n_alloc == 2'd2;

  // Retire decision uses the registered done bits only: a completion written
  // at this edge becomes visible to retirement one edge later.
  rob_retire_sel u_retire_sel (
    .head_v    (rob_q[head_q].v),
    .head_done (rob_q[head_q].done),
    .next_v    (rob_q[head_p1].v),
    .next_done (rob_q[head_p1].done),
    .ret_en_1  (ret_en_1),
    .ret_en_2  (ret_en_2),
    .n_retire  (n_retire)
  );

  // Next-state of the entry array. Completions are gated by the pre-edge
  // valid bit so strobes to empty slots (including a slot being allocated
  // at this same edge) have no effect. Retirement clears after completion,
  // so a late strobe to a retiring entry cannot resurrect it. Allocation
  // never targets a retiring entry because ready requires two free slots.
  always_comb begin
    rob_d = rob_q;
    for (int k = 0; k < N_CMP; k++) begin
      if (cmp_valid[k] && rob_q[cmp_idx[k*IDX_W +: IDX_W]].v) begin
        rob_d[cmp_idx[k*IDX_W +: IDX_W]].done = 1'b1;
      end
    end
    if (ret_en_1) begin
      rob_d[head_q].v    = 1'b0;
      rob_d[head_q].done = 1'b0;
    end
    if (ret_en_2) begin
      rob_d[head_p1].v    = 1'b0;
      rob_d[head_p1].done = 1'b0;
    end
    if (accept_1) begin
      rob_d[tail_q] = '{v: 1'b1, done: 1'b0, rd: alloc_rd_1, pd: alloc_pd_1,
                        old_pd: alloc_old_pd_1, has_dest: alloc_has_dest_1,
                        pc: alloc_pc_1};
    end
    if (accept_2) begin
      rob_d[tail_p1] = '{v: 1'b1, done: 1'b0, rd: alloc_rd_2, pd: alloc_pd_2,
                         old_pd: alloc_old_pd_2, has_dest: alloc_has_dest_2,
                         pc: alloc_pc_2};
    end
  end

  // Reset and flush both empty the ROB and silence the retire ports; reset
  // wins simply because it is checked first in the same condition.
  always_ff @(posedge clk) begin
    if (rst || flush_w) begin
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        rob_q[i] <= '0;
      end
      ret_valid_1  <= 1'b0;
      ret_valid_2  <= 1'b0;
      ret_free_1   <= 1'b0;
      ret_free_2   <= 1'b0;
      ret_rd_1     <= '0;
      ret_rd_2     <= '0;
      ret_pd_1     <= '0;
      ret_pd_2     <= '0;
      ret_old_pd_1 <= '0;
      ret_old_pd_2 <= '0;
      ret_pc_1     <= '0;
      ret_pc_2     <= '0;
    end else begin
      rob_q        <= rob_d;
      head_q       <= head_q + IDX_W'(n_retire);
      tail_q       <= tail_q + IDX_W'(n_alloc);
      count_q      <= count_q + (IDX_W+1)'(n_alloc) - (IDX_W+1)'(n_retire);
      ret_valid_1  <= ret_en_1;
      ret_valid_2  <= ret_en_2;
      ret_free_1   <= ret_en_1 & rob_q[head_q].has_dest;
      ret_free_2   <= ret_en_2 & rob_q[head_p1].has_dest;
      ret_rd_1     <= rob_q[head_q].rd;
      ret_rd_2     <= rob_q[head_p1].rd;
      ret_pd_1     <= rob_q[head_q].pd;
      ret_pd_2     <= rob_q[head_p1].pd;
      ret_old_pd_1 <= rob_q[head_q].old_pd;
      ret_old_pd_2 <= rob_q[head_p1].old_pd;
      ret_pc_1     <= rob_q[head_q].pc;
      ret_pc_2     <= rob_q[head_p1].pc;
    end
  end

endmodule

// File: tb/tb_rob_commit.sv
// tb_rob_commit: directed bench for rob_commit with a queue-based reference
// model and a per-cycle compare process. Flush scenario is built only when
// ROB_FLUSH_EN is defined.
module tb_rob_commit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        alloc_valid_1 = 1'b0, alloc_valid_2 = 1'b0;
  logic [4:0]  alloc_rd_1 = '0, alloc_rd_2 = '0;
  logic [5:0]  alloc_pd_1 = '0, alloc_pd_2 = '0;
  logic [5:0]  alloc_old_pd_1 = '0, alloc_old_pd_2 = '0;
  logic        alloc_has_dest_1 = 1'b0, alloc_has_dest_2 = 1'b0;
  logic [31:0] alloc_pc_1 = '0, alloc_pc_2 = '0;
  logic        alloc_ready;
  logic [3:0]  alloc_idx_1, alloc_idx_2;
  logic [2:0]  cmp_valid = '0;
  logic [11:0] cmp_idx = '0;
  logic        ret_valid_1, ret_valid_2;
  logic [4:0]  ret_rd_1, ret_rd_2;
  logic [5:0]  ret_pd_1, ret_pd_2, ret_old_pd_1, ret_old_pd_2;
  logic        ret_free_1, ret_free_2;
  logic [31:0] ret_pc_1, ret_pc_2;
  logic [4:0]  count;

  int n_checks = 0;
  int n_errors = 0;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  rob_commit dut (
    .clk              (clk),
    .rst              (rst),
`ifdef ROB_FLUSH_EN
    .flush            (flush),
`endif
    .alloc_valid_1    (alloc_valid_1),
    .alloc_valid_2    (alloc_valid_2),
    .alloc_rd_1       (alloc_rd_1),
    .alloc_rd_2       (alloc_rd_2),
    .alloc_pd_1       (alloc_pd_1),
    .alloc_pd_2       (alloc_pd_2),
    .alloc_old_pd_1   (alloc_old_pd_1),
    .alloc_old_pd_2   (alloc_old_pd_2),
    .alloc_has_dest_1 (alloc_has_dest_1),
    .alloc_has_dest_2 (alloc_has_dest_2),
    .alloc_pc_1       (alloc_pc_1),
    .alloc_pc_2       (alloc_pc_2),
    .alloc_ready      (alloc_ready),
    .alloc_idx_1      (alloc_idx_1),
    .alloc_idx_2      (alloc_idx_2),
    .cmp_valid        (cmp_valid),
    .cmp_idx          (cmp_idx),
    .ret_valid_1      (ret_valid_1),
    .ret_valid_2      (ret_valid_2),
    .ret_rd_1         (ret_rd_1),
    .ret_rd_2         (ret_rd_2),
    .ret_pd_1         (ret_pd_1),
    .ret_pd_2         (ret_pd_2),
    .ret_old_pd_1     (ret_old_pd_1),
    .ret_old_pd_2     (ret_old_pd_2),
    .ret_free_1       (ret_free_1),
    .ret_free_2       (ret_free_2),
    .ret_pc_1         (ret_pc_1),
    .ret_pc_2         (ret_pc_2),
    .count            (count)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Occupancy is a program-ordered queue; the oldest element is the head.
  typedef struct {
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [5:0]  pd;
    logic [5:0]  old_pd;
    logic        hd;
    logic        done;
    int          idx;
  } ment_t;

  ment_t       m_q[$];
  int          m_tail = 0;
  ment_t       e_r1, e_r2, m_new;
  logic        e_v1 = 1'b0, e_v2 = 1'b0;
  logic [31:0] exp_q[$];   // PCs in program order, popped on observed retire
  bit          started = 1'b0;
  int          m_sz;

  always @(posedge clk) begin
    if (rst || flush) begin
      m_q.delete();
      exp_q.delete();
      m_tail = 0;
      e_v1 = 1'b0;
      e_v2 = 1'b0;
      if (rst) started = 1'b1;
    end else begin
      m_sz = m_q.size();
      e_v1 = 1'b0;
      e_v2 = 1'b0;
      if (m_sz >= 1 && m_q[0].done) begin
        e_v1 = 1'b1;
        e_r1 = m_q[0];
        if (m_sz >= 2 && m_q[1].done) begin
          e_v2 = 1'b1;
          e_r2 = m_q[1];
        end
      end
      if (e_v1) void'(m_q.pop_front());
      if (e_v2) void'(m_q.pop_front());
      for (int k = 0; k < 3; k++) begin
        if (cmp_valid[k]) begin
          foreach (m_q[j]) begin
            if (m_q[j].idx == int'(cmp_idx[k*4 +: 4])) m_q[j].done = 1'b1;
          end
        end
      end
      if (m_sz <= 14 && alloc_valid_1) begin
        m_new = '{pc: alloc_pc_1, rd: alloc_rd_1, pd: alloc_pd_1, old_pd: alloc_old_pd_1,
                  hd: alloc_has_dest_1, done: 1'b0, idx: m_tail};
        m_q.push_back(m_new);
        exp_q.push_back(alloc_pc_1);
        m_tail = (m_tail + 1) % 16;
        if (alloc_valid_2) begin
          m_new = '{pc: alloc_pc_2, rd: alloc_rd_2, pd: alloc_pd_2, old_pd: alloc_old_pd_2,
                    hd: alloc_has_dest_2, done: 1'b0, idx: m_tail};
          m_q.push_back(m_new);
          exp_q.push_back(alloc_pc_2);
          m_tail = (m_tail + 1) % 16;
        end
      end
    end
  end

  // ---------------- scoreboard / compare ----------------
  always @(negedge clk) begin
    if (started) begin
      chk("count", count, m_q.size());
      chk("alloc_ready", alloc_ready, m_q.size() <= 14);
      chk("alloc_idx_1", alloc_idx_1, m_tail);
      chk("alloc_idx_2", alloc_idx_2, (m_tail + 1) % 16);
      chk("ret_valid_1", ret_valid_1, e_v1);
      chk("ret_valid_2", ret_valid_2, e_v2);
      chk("ret_free_1", ret_free_1, e_v1 & e_r1.hd);
      chk("ret_free_2", ret_free_2, e_v2 & e_r2.hd);
      if (e_v1) begin
        chk("ret_rd_1", ret_rd_1, e_r1.rd);
        chk("ret_pd_1", ret_pd_1, e_r1.pd);
        chk("ret_pc_1", ret_pc_1, e_r1.pc);
        if (e_r1.hd) chk("ret_old_pd_1", ret_old_pd_1, e_r1.old_pd);
      end
      if (e_v2) begin
        chk("ret_rd_2", ret_rd_2, e_r2.rd);
        chk("ret_pd_2", ret_pd_2, e_r2.pd);
        chk("ret_pc_2", ret_pc_2, e_r2.pc);
        if (e_r2.hd) chk("ret_old_pd_2", ret_old_pd_2, e_r2.old_pd);
      end
      if (ret_valid_1) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL order_1 actual=retire pc %0h expected=no pending entry", ret_pc_1);
        end else chk("order_pc_1", ret_pc_1, exp_q.pop_front());
      end
      if (ret_valid_2) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL order_2 actual=retire pc %0h expected=no pending entry", ret_pc_2);
        end else chk("order_pc_2", ret_pc_2, exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
      #1;
    end
  endtask

  task automatic idle();
    alloc_valid_1 = 1'b0;
    alloc_valid_2 = 1'b0;
    cmp_valid     = '0;
    cmp_idx       = '0;
  endtask

  // Slot 2 gets pc+4, rd+1, pd+1, old_pd+1.
  task automatic drive_alloc(input logic v1, input logic v2, input logic [31:0] pc,
                             input logic [5:0] pd, input logic [5:0] old_pd,
                             input logic hd1, input logic hd2);
    alloc_valid_1    = v1;
    alloc_valid_2    = v2;
    alloc_pc_1       = pc;
    alloc_pc_2       = pc + 32'd4;
    alloc_rd_1       = pc[6:2];
    alloc_rd_2       = pc[6:2] + 5'd1;
    alloc_pd_1       = pd;
    alloc_pd_2       = pd + 6'd1;
    alloc_old_pd_1   = old_pd;
    alloc_old_pd_2   = old_pd + 6'd1;
    alloc_has_dest_1 = hd1;
    alloc_has_dest_2 = hd2;
  endtask

  task automatic drive_cmp(input logic [2:0] v, input logic [3:0] i0,
                           input logic [3:0] i1, input logic [3:0] i2);
    cmp_valid = v;
    cmp_idx   = {i2, i1, i0};
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst = 1'b1;
    idle();
    step(2);
    rst = 1'b0;
    chk("lit_reset_count", count, 0);
    chk("lit_reset_ready", alloc_ready, 1);
    chk("lit_reset_idx1", alloc_idx_1, 0);
    chk("lit_reset_ret_v1", ret_valid_1, 0);

    // Two-entry retire, completion of idx1 before idx0.
    drive_alloc(1, 1, 32'h0, 6'd32, 6'd1, 1, 1);
    step();
    idle();
    chk("lit_t1_count2", count, 2);
    drive_cmp(3'b001, 4'd1, 4'd0, 4'd0);
    step();
    idle();
    chk("lit_t1_noret_a", ret_valid_1, 0);
    drive_cmp(3'b001, 4'd0, 4'd0, 4'd0);
    step();
    idle();
    chk("lit_t1_nobypass", ret_valid_1, 0);
    step();
    chk("lit_t1_rv1", ret_valid_1, 1);
    chk("lit_t1_rv2", ret_valid_2, 1);
    chk("lit_t1_old1", ret_old_pd_1, 1);
    chk("lit_t1_old2", ret_old_pd_2, 2);
    chk("lit_t1_free", {ret_free_1, ret_free_2}, 2'b11);
    chk("lit_t1_count0", count, 0);

    // Out-of-order completion over indices 2..5.
    drive_alloc(1, 1, 32'h100, 6'd40, 6'd10, 1, 1);
    step();
    drive_alloc(1, 1, 32'h108, 6'd42, 6'd12, 1, 0);
    step();
    idle();
    drive_cmp(3'b001, 4'd5, 4'd0, 4'd0);
    step();
    drive_cmp(3'b001, 4'd4, 4'd0, 4'd0);
    step();
    drive_cmp(3'b011, 4'd2, 4'd3, 4'd0);
    step();
    idle();
    chk("lit_t2_wait", ret_valid_1, 0);
    step();
    chk("lit_t2_pc1a", ret_pc_1, 32'h100);
    chk("lit_t2_pc2a", ret_pc_2, 32'h104);
    step();
    chk("lit_t2_pc1b", ret_pc_1, 32'h108);
    chk("lit_t2_free2b", ret_free_2, 0);
    chk("lit_t2_count", count, 0);

    // Full: head=tail=6, eight pairs fill all 16 entries.
    for (int j = 0; j < 8; j++) begin
      drive_alloc(1, 1, 32'h400 + 32'(8 * j), 6'(2 * j), 6'(20 + 2 * j), 1, 1);
      step();
    end
    idle();
    chk("lit_full_count", count, 16);
    chk("lit_full_ready", alloc_ready, 0);
    drive_alloc(1, 1, 32'h480, 6'd50, 6'd51, 1, 1);
    step();
    idle();
    chk("lit_full_drop_count", count, 16);
    chk("lit_full_drop_tail", alloc_idx_1, 6);
    drive_cmp(3'b011, 4'd6, 4'd7, 4'd0);
    step();
    idle();
    chk("lit_full_still", count, 16);
    step();
    chk("lit_full_count14", count, 14);
    chk("lit_full_ready14", alloc_ready, 1);
    chk("lit_full_pc", ret_pc_1, 32'h400);

    // Simultaneous allocate 2 / retire 2 at count 14, then mid-stream reset.
    drive_cmp(3'b011, 4'd8, 4'd9, 4'd0);
    step();
    idle();
    drive_alloc(1, 1, 32'h500, 6'd60, 6'd30, 1, 1);
    step();
    idle();
    chk("lit_sim_count", count, 14);
    chk("lit_sim_pc1", ret_pc_1, 32'h408);
    chk("lit_sim_pc2", ret_pc_2, 32'h40c);
    drive_cmp(3'b011, 4'd10, 4'd11, 4'd0);
    step();
    idle();
    rst = 1'b1;
    drive_alloc(1, 1, 32'h520, 6'd61, 6'd31, 1, 1);
    drive_cmp(3'b001, 4'd12, 4'd0, 4'd0);
    step();
    rst = 1'b0;
    idle();
    chk("lit_rst_count", count, 0);
    chk("lit_rst_rv1", ret_valid_1, 0);
    chk("lit_rst_rv2", ret_valid_2, 0);
    chk("lit_rst_free1", ret_free_1, 0);
    chk("lit_rst_idx1", alloc_idx_1, 0);

    // Wrap: walk head/tail to 15, then allocate a pair spanning 15 -> 0.
    for (int i = 0; i < 7; i++) begin
      drive_alloc(1, 1, 32'h300 + 32'(16 * i), 6'(i), 6'(i + 8), 1, i[0]);
      step();
      idle();
      drive_cmp(3'b011, 4'(2 * i), 4'(2 * i + 1), 4'd0);
      step();
      idle();
      step();
    end
    drive_alloc(1, 0, 32'h3f0, 6'd7, 6'd15, 0, 0);
    step();
    idle();
    drive_cmp(3'b001, 4'd14, 4'd0, 4'd0);
    step();
    idle();
    step();
    chk("lit_wrap_idx1", alloc_idx_1, 15);
    chk("lit_wrap_idx2", alloc_idx_2, 0);
    drive_alloc(1, 1, 32'h200, 6'd44, 6'd3, 1, 1);
    step();
    idle();
    drive_cmp(3'b001, 4'd0, 4'd0, 4'd0);
    step();
    drive_cmp(3'b001, 4'd15, 4'd0, 4'd0);
    step();
    idle();
    chk("lit_wrap_noret", ret_valid_1, 0);
    step();
    chk("lit_wrap_pc1", ret_pc_1, 32'h200);
    chk("lit_wrap_pc2", ret_pc_2, 32'h204);
    chk("lit_wrap_head", count, 0);

`ifdef ROB_FLUSH_EN
    // Flush with 6 entries (idx1..6), the three oldest done.
    for (int j = 0; j < 3; j++) begin
      drive_alloc(1, 1, 32'h600 + 32'(8 * j), 6'(2 * j), 6'(2 * j + 1), 1, 1);
      step();
    end
    idle();
    drive_cmp(3'b111, 4'd1, 4'd2, 4'd3);
    step();
    idle();
    flush = 1'b1;
    drive_alloc(1, 1, 32'h700, 6'd9, 6'd9, 1, 1);
    drive_cmp(3'b001, 4'd4, 4'd0, 4'd0);
    step();
    flush = 1'b0;
    idle();
    chk("lit_flush_rv1", ret_valid_1, 0);
    chk("lit_flush_count", count, 0);
    chk("lit_flush_idx1", alloc_idx_1, 0);
    step(2);
`endif

    step(2);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
